rc4_encrypt_fsm: RTL and testbench

// - RC4 encryptor with a fixed 24-bit key. Transmit-side counterpart of the brute-force decryption path.
// - Builds the S-box in the external 256x8 S RAM (init + KSA), then runs PRGA over MSG_LEN plaintext bytes.
// - Writes the resulting ciphertext into the message RAM that the decryption path later reads.
// - Single shared S-RAM port, arbitrated internally by the state machine.

---
 rtl/rc4_encrypt_fsm.sv | 231 +++++++++++++++++++++++
 tb/tb_rc4_encrypt_fsm.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_encrypt_fsm.sv
// RC4 encryptor with a fixed 24-bit key: builds S in the shared S RAM
// (init + KSA), then runs PRGA over the plaintext into the ciphertext RAM.
module rc4_encrypt_fsm #(
    parameter int MSG_LEN = 32,
    parameter int RD_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] key,
    output logic        busy,
    output logic        done,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wdata,
    output logic        s_wren,
    input  logic [7:0]  s_q,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_q,
    output logic [7:0]  ct_addr,
    output logic [7:0]  ct_wdata,
    output logic        ct_wren
);

    localparam int CW = (RD_WAIT < 1) ? 1 : $clog2(RD_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_WAIT);
    localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, INIT,
        K_RI, K_RJ, K_WI, K_WJ,
        P_RI, P_RJ, P_WI, P_WJ, P_RF, P_RP, P_WC
    } state_e;

    state_e state_q, state_d;
    logic [23:0] key_q, key_d;
    logic [7:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [7:0]  si_q, si_d, sj_q, sj_d, f_q, f_d, ct_q, ct_d;
    logic [1:0]  m_q, m_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [7:0]  kbyte;
    logic        rd_st, rd_last;

    // key byte selected by i mod 3, tracked by m
    always_comb begin
        kbyte = key_q[7:0];
        unique case (m_q)
            2'd0: kbyte = key_q[23:16];
            2'd1: kbyte = key_q[15:8];
            default: kbyte = key_q[7:0];
        endcase
    end

    assign rd_st = (state_q == K_RI) || (state_q == K_RJ) ||
                   (state_q == P_RI) || (state_q == P_RJ) ||
                   (state_q == P_RF) || (state_q == P_RP);
    assign rd_last = (cnt_q == CNT_LAST);

    // state register and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            m_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            f_q     <= '0;
            ct_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            m_q     <= m_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            ct_q    <= ct_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // next-state, RAM port arbitration and datapath updates
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        m_d      = m_q;
        si_d     = si_q;
        sj_d     = sj_q;
        f_d      = f_q;
        ct_d     = ct_q;
        cnt_d    = '0;
        done_d   = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wren   = 1'b0;
        pt_addr  = '0;
        ct_addr  = '0;
        ct_wdata = '0;
        ct_wren  = 1'b0;
        if (rd_st) begin
            cnt_d = rd_last ? '0 : cnt_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    m_d     = '0;
                    state_d = INIT;
                end
            end
            INIT: begin
                s_addr  = i_q;
                s_wdata = i_q;
                s_wren  = 1'b1;
                i_d     = i_q + 8'd1;
                if (i_q == 8'hFF) begin
                    j_d     = '0;
                    state_d = K_RI;
                end
            end
            K_RI: begin
                s_addr = i_q;
                if (rd_last) begin
                    si_d    = s_q;
                    j_d     = j_q + s_q + kbyte;
                    state_d = K_RJ;
                end
            end
            K_RJ: begin
                s_addr = j_q;
                if (rd_last) begin
                    sj_d    = s_q;
                    state_d = K_WI;
                end
            end
            K_WI: begin
                s_addr  = i_q;
                s_wdata = sj_q;
                s_wren  = 1'b1;
                state_d = K_WJ;
            end
            K_WJ: begin
                s_addr  = j_q;
                s_wdata = si_q;
                s_wren  = 1'b1;
                i_d     = i_q + 8'd1;
                m_d     = (m_q == 2'd2) ? 2'd0 : m_q + 2'd1;
                state_d = K_RI;
                if (i_q == 8'hFF) begin
                    i_d     = 8'd1;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = P_RI;
                end
            end
            P_RI: begin
                s_addr = i_q;
                if (rd_last) begin
                    si_d    = s_q;
                    j_d     = j_q + s_q;
                    state_d = P_RJ;
                end
            end
            P_RJ: begin
                s_addr = j_q;
                if (rd_last) begin
                    sj_d    = s_q;
                    state_d = P_WI;
                end
            end
            P_WI: begin
                s_addr  = i_q;
                s_wdata = sj_q;
                s_wren  = 1'b1;
                state_d = P_WJ;
            end
            P_WJ: begin
                s_addr  = j_q;
                s_wdata = si_q;
                s_wren  = 1'b1;
                state_d = P_RF;
            end
            P_RF: begin
                s_addr = si_q + sj_q;
                if (rd_last) begin
                    f_d     = s_q;
                    state_d = P_RP;
                end
            end
            P_RP: begin
                pt_addr = k_q;
                if (rd_last) begin
                    ct_d    = f_q ^ pt_q;
                    state_d = P_WC;
                end
            end
            P_WC: begin
                ct_addr  = k_q;
                ct_wdata = ct_q;
                ct_wren  = 1'b1;
                if (k_q == K_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    k_d     = k_q + 8'd1;
                    i_d     = i_q + 8'd1;
                    state_d = P_RI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_rc4_encrypt_fsm.sv
// Bench for rc4_encrypt_fsm: RAM models, RC4 reference model and a
// ciphertext scoreboard fed per run, plus reset/start/key corner cases.
module tb_rc4_encrypt_fsm;

    localparam int MSG_LEN = 32;
    localparam int RD_WAIT = 2;
    localparam int TMO = 6000;

    logic clk = 1'b0;
    logic reset, start;
    logic [23:0] key;
    logic busy, done, s_wren, ct_wren;
    logic [7:0] s_addr, s_wdata, s_q, pt_addr, pt_q, ct_addr, ct_wdata;

    rc4_encrypt_fsm #(.MSG_LEN(MSG_LEN), .RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .reset(reset), .start(start), .key(key),
        .busy(busy), .done(done),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_q(s_q),
        .pt_addr(pt_addr), .pt_q(pt_q),
        .ct_addr(ct_addr), .ct_wdata(ct_wdata), .ct_wren(ct_wren)
    );

    always #5 clk = ~clk;

    logic [7:0] s_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] s_p1, pt_p1;

    // synchronous RAMs with two-cycle read latency
    always @(posedge clk) begin
        if (s_wren) s_mem[s_addr] <= s_wdata;
        s_p1  <= s_mem[s_addr];
        s_q   <= s_p1;
        pt_p1 <= pt_mem[pt_addr];
        pt_q  <= pt_p1;
        if (ct_wren) ct_mem[ct_addr] <= ct_wdata;
    end

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int swr_cnt = 0;
    logic [15:0] exp_q [$];
    logic [7:0] rs [256];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // scoreboard: every ciphertext write is popped and compared
    always @(negedge clk) begin
        logic [15:0] e;
        if (done) done_cnt++;
        if (s_wren) swr_cnt++;
        if (ct_wren) begin
            checks++;
            if (s_wren) begin
                errors++;
                $display("FAIL wren_overlap: s_wren=1 with ct_wren=1");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ct_unexpected: got addr=%0d data=%02h required none",
                         ct_addr, ct_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({ct_addr, ct_wdata} !== e) begin
                    errors++;
                    $display("FAIL ct_byte: got addr=%0d data=%02h required addr=%0d data=%02h",
                             ct_addr, ct_wdata, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic model_ksa(input logic [23:0] k);
        logic [7:0] j, t, kb;
        for (int n = 0; n < 256; n++) rs[n] = 8'(n);
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            kb = (n % 3 == 0) ? k[23:16] : (n % 3 == 1) ? k[15:8] : k[7:0];
            j = j + rs[n] + kb;
            t = rs[n];
            rs[n] = rs[j];
            rs[j] = t;
        end
    endtask

    task automatic push_expected(input logic [23:0] k);
        logic [7:0] ss [256];
        logic [7:0] i, j, t, x;
        model_ksa(k);
        ss = rs;
        i = 8'd0;
        j = 8'd0;
        for (int n = 0; n < MSG_LEN; n++) begin
            i = i + 8'd1;
            j = j + ss[i];
            t = ss[i];
            ss[i] = ss[j];
            ss[j] = t;
            x = ss[i] + ss[j];
            exp_q.push_back({8'(n), ss[x] ^ pt_mem[n]});
        end
    endtask

    task automatic wait_done(input string nm);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < TMO) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk({nm, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({nm, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_start(input logic [23:0] k);
        done_cnt = 0;
        swr_cnt = 0;
        key = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_run(input logic [23:0] k, input bit chk_init,
                          input string nm);
        bit bad;
        push_expected(k);
        pulse_start(k);
        if (chk_init) begin
            chk("busy_after_start", 32'(busy), 32'd1);
            bad = 1'b0;
            for (int n = 0; n < 256; n++) begin
                if (!bad && (s_wren !== 1'b1 || s_addr !== 8'(n) ||
                             s_wdata !== 8'(n))) begin
                    bad = 1'b1;
                    $display("FAIL init_write: n=%0d got wren=%0b addr=%0d data=%0d",
                             n, s_wren, s_addr, s_wdata);
                end
                @(negedge clk);
            end
            checks++;
            if (bad) errors++;
        end
        wait_done(nm);
    endtask

    task automatic set_pt(input int kind);
        logic [71:0] ptxt;
        ptxt = "Plaintext";
        for (int n = 0; n < 256; n++) begin
            unique case (kind)
                0: pt_mem[n] = (n < 9) ? ptxt[71-8*n -: 8] : 8'(n * 7 + 3);
                1: pt_mem[n] = 8'h00;
                2: pt_mem[n] = 8'hFF;
                default: pt_mem[n] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    typedef struct {
        logic [23:0] key;
        int          kind;
        bit          has_exp;
        logic [71:0] exp9;
    } vec_t;

    vec_t vecs [4];
    logic [7:0] orig [256];

    initial begin
        int bad;
        logic [71:0] e9;
        vecs[0] = '{24'h4B6579, 0, 1'b1, 72'hBBF316E8D940AF0AD3};
        vecs[1] = '{24'h000000, 1, 1'b0, 72'h0};
        vecs[2] = '{24'hFFFFFF, 2, 1'b0, 72'h0};
        vecs[3] = '{24'h0102FE, 3, 1'b0, 72'h0};

        reset = 1'b1;
        start = 1'b0;
        key = '0;
        set_pt(0);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s_wren", 32'(s_wren), 32'd0);
        chk("rst_ct_wren", 32'(ct_wren), 32'd0);
        chk("rst_addrs", {8'h0, s_addr, pt_addr, ct_addr}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            set_pt(vecs[v].kind);
            do_run(vecs[v].key, v == 0, $sformatf("vec%0d", v));
            if (vecs[v].has_exp) begin
                e9 = vecs[v].exp9;
                for (int n = 0; n < 9; n++)
                    chk($sformatf("known_ct%0d", n), 32'(ct_mem[n]),
                        32'(e9[71-8*n -: 8]));
            end
        end

        set_pt(3);
        for (int n = 0; n < 256; n++) orig[n] = pt_mem[n];
        do_run(24'h000249, 1'b0, "rt_enc");
        for (int n = 0; n < MSG_LEN; n++) pt_mem[n] = ct_mem[n];
        for (int n = 0; n < MSG_LEN; n++) exp_q.push_back({8'(n), orig[n]});
        pulse_start(24'h000249);
        wait_done("rt_dec");
        bad = 0;
        for (int n = 0; n < MSG_LEN; n++) if (ct_mem[n] !== orig[n]) bad++;
        chk("rt_ct_eq_pt", 32'(bad), 32'd0);

        set_pt(0);
        push_expected(24'h4B6579);
        done_cnt = 0;
        key = 24'h4B6579;
        start = 1'b1;
        repeat (1000) @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("start_held");

        set_pt(3);
        pulse_start(24'hA5C301);
        repeat (600) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_wren", {30'h0, s_wren, ct_wren}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        do_run(24'hA5C301, 1'b0, "after_rst");

        set_pt(2);
        push_expected(24'h13579B);
        pulse_start(24'h13579B);
        key = 24'hFFFFFF;
        bad = 0;
        while (swr_cnt < 768 && bad < TMO) begin
            @(negedge clk);
            key = key ^ 24'h5A5A5A;
            bad++;
        end
        chk("ksa_reached", 32'(swr_cnt >= 768), 32'd1);
        @(posedge clk);
        #1;
        bad = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== rs[n]) bad++;
        chk("ksa_sbox", 32'(bad), 32'd0);
        wait_done("key_change");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
